// File: rtl/uart_sram_tx_interface_pkg.sv
// Shared types and constants for the UART/SRAM interface blocks.
// Holds the top-level and transmit-side state encodings plus the default baud divider.
package uart_sram_tx_interface_pkg;

  // 50 MHz system clock divided down to 115200 baud
  localparam int BAUD_50M_115200 = 434;

  // Cycles from a registered SRAM address to usable read data
  localparam int SRAM_READ_LATENCY = 2;

  // Top-level controller states (receive path, transmit path)
  typedef enum logic [1:0] {
    S_TOP_IDLE,
    S_TOP_RECEIVE,
    S_TOP_TRANSMIT
  } top_state_type;

  // Transmit-side dump sequencer states
  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_READ,
    S_TX_WAIT,
    S_TX_HI,
    S_TX_LO,
    S_TX_FINISH
  } tx_state_type;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A frame is start(0), 8 data bits LSB first, stop(1),
// each held CLKS_PER_BIT cycles. Ready is also high in the final cycle of the
// stop bit so a Load taken there starts the next frame with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [7:0] Data,
  output logic       TX,
  output logic       Ready
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST_TICK = BW'(CLKS_PER_BIT - 1);

  logic [BW-1:0] baud_reg;
  logic [3:0]    bit_cnt_reg;
  logic [9:0]    shift_reg;
  logic [9:0]    shift_next;
  logic          active_reg;
  logic          bit_end;

  assign bit_end = (baud_reg == LAST_TICK);
  assign Ready   = !active_reg || (bit_end && (bit_cnt_reg == 4'd9));
  // Line is driven straight from a flop; reset fills the register with ones
  assign TX      = shift_reg[0];

  // Shift towards bit 0, back-filling with idle-high ones
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_shift
      assign shift_next[gi] = shift_reg[gi+1];
    end
  endgenerate
  assign shift_next[9] = 1'b1;

  // Baud timing, bit counting and frame shifting
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      active_reg  <= 1'b0;
      baud_reg    <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '1;
    end else if (Load && Ready) begin
      active_reg  <= 1'b1;
      baud_reg    <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= {1'b1, Data, 1'b0};
    end else if (active_reg) begin
      if (bit_end) begin
        baud_reg  <= '0;
        shift_reg <= shift_next;
        if (bit_cnt_reg == 4'd9) begin
          active_reg <= 1'b0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else begin
        baud_reg <= baud_reg + BW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// Dumps a range of 16-bit SRAM words over UART, high byte first, frames back to back.
// The next word is fetched while the current low byte is on the line.
// Optional macro UART_TX_CHECKSUM_EN appends a 16-bit sum-of-words trailer word.
module uart_sram_tx_interface
  import uart_sram_tx_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = BAUD_50M_115200,
  parameter int READ_LATENCY = SRAM_READ_LATENCY
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);

  tx_state_type state_reg, state_next;

  logic [17:0]   addr_reg;       // next address to read
  logic [17:0]   remaining_reg;  // words not yet fetched
  logic [17:0]   sram_addr_reg;
  logic [15:0]   word_buf_reg;   // current word; after its low byte is loaded it holds the prefetch
  logic          fetch_busy_reg;
  logic [LW-1:0] lat_reg;
  logic          last_sent_reg;  // final low byte has been handed to the serializer

  logic       accept, issue_read, capture, set_last;
  logic       tx_load, tx_ready;
  logic [7:0] tx_data;
`ifdef UART_TX_CHECKSUM_EN
  logic [15:0] sum_reg;
  logic        trailer_reg;
  logic        load_trailer;
`endif

  assign capture      = fetch_busy_reg && (lat_reg == LAT_LAST);
  assign SRAM_address = sram_addr_reg;
  assign SRAM_we_n    = 1'b1;
  assign Busy         = state_reg inside {S_TX_READ, S_TX_WAIT, S_TX_HI, S_TX_LO};
  assign Done         = (state_reg == S_TX_FINISH);

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_byte (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Load   (tx_load),
    .Data   (tx_data),
    .TX     (UART_TX_O),
    .Ready  (tx_ready)
  );

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_reg <= S_TX_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state and control decode
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    issue_read = 1'b0;
    set_last   = 1'b0;
    tx_load    = 1'b0;
    tx_data    = word_buf_reg[15:8];
`ifdef UART_TX_CHECKSUM_EN
    load_trailer = 1'b0;
`endif
    case (state_reg)
      S_TX_IDLE: begin
        if (Start) begin
          if (Word_count != '0) begin
            accept     = 1'b1;
            state_next = S_TX_READ;
          end else begin
`ifdef UART_TX_CHECKSUM_EN
            accept       = 1'b1;
            load_trailer = 1'b1;
            state_next   = S_TX_HI;
`else
            state_next = S_TX_FINISH;
`endif
          end
        end
      end
      S_TX_READ: begin
        issue_read = 1'b1;
        state_next = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (capture) state_next = S_TX_HI;
      end
      S_TX_HI: begin
        if (tx_ready) begin
          tx_load    = 1'b1;
          state_next = S_TX_LO;
        end
      end
      S_TX_LO: begin
        tx_data = word_buf_reg[7:0];
        if (tx_ready) begin
          if (last_sent_reg) begin
            state_next = S_TX_FINISH;
          end else begin
            tx_load = 1'b1;
            if (remaining_reg != '0) begin
              issue_read = 1'b1;
              state_next = S_TX_HI;
            end
`ifdef UART_TX_CHECKSUM_EN
            else if (!trailer_reg) begin
              load_trailer = 1'b1;
              state_next   = S_TX_HI;
            end
`endif
            else begin
              set_last = 1'b1;
            end
          end
        end
      end
      S_TX_FINISH: state_next = S_TX_IDLE;
      default:     state_next = S_TX_IDLE;
    endcase
  end

  // Address sequencing, read-latency tracking and word capture
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      addr_reg       <= '0;
      remaining_reg  <= '0;
      sram_addr_reg  <= '0;
      word_buf_reg   <= '0;
      fetch_busy_reg <= 1'b0;
      lat_reg        <= '0;
      last_sent_reg  <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg      <= Start_address;
        remaining_reg <= Word_count;
        last_sent_reg <= 1'b0;
      end
      if (issue_read) begin
        sram_addr_reg  <= addr_reg;
        addr_reg       <= addr_reg + 18'd1;
        fetch_busy_reg <= 1'b1;
        lat_reg        <= '0;
      end else if (fetch_busy_reg) begin
        if (capture) begin
          word_buf_reg   <= SRAM_read_data;
          remaining_reg  <= remaining_reg - 18'd1;
          fetch_busy_reg <= 1'b0;
        end else begin
          lat_reg <= lat_reg + LW'(1);
        end
      end
`ifdef UART_TX_CHECKSUM_EN
      if (load_trailer) word_buf_reg <= sum_reg;
`endif
      if (set_last) last_sent_reg <= 1'b1;
    end
  end

`ifdef UART_TX_CHECKSUM_EN
  // Running sum of fetched words; cleared on completion so the next dump starts at zero
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sum_reg     <= '0;
      trailer_reg <= 1'b0;
    end else begin
      if (state_reg == S_TX_FINISH) sum_reg <= '0;
      else if (capture)             sum_reg <= sum_reg + SRAM_read_data;
      if (accept)       trailer_reg <= 1'b0;
      if (load_trailer) trailer_reg <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_sram_tx_interface.sv
// Directed bench for uart_sram_tx_interface: SRAM model, UART frame decoder and
// address logger, with one task per scenario. Honors UART_TX_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_uart_sram_tx_interface;

  localparam int C     = 434;
  localparam int FRAME = 10 * C;
`ifdef UART_TX_CHECKSUM_EN
  localparam int TRAILER = 1;
`else
  localparam int TRAILER = 0;
`endif

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic [17:0] Start_address = '0;
  logic [17:0] Word_count = '0;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic        SRAM_we_n, UART_TX_O, Busy, Done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_errs = 0;

  logic [15:0] mem [0:262143];
  byte unsigned rx_q[$];
  byte unsigned exp_q[$];
  int           st_q[$];
  logic [17:0]  addr_log[$];
  logic [17:0]  last_addr = '0;
  int           mon_t0;
  logic [7:0]   mon_b;

  uart_sram_tx_interface dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .Start          (Start),
    .Start_address  (Start_address),
    .Word_count     (Word_count),
    .SRAM_address   (SRAM_address),
    .SRAM_read_data (SRAM_read_data),
    .SRAM_we_n      (SRAM_we_n),
    .UART_TX_O      (UART_TX_O),
    .Busy           (Busy),
    .Done           (Done)
  );

  always #5 Clock = ~Clock;

  // Cycle counter and SRAM model: address registered at edge k is readable at edge k+2
  always @(posedge Clock) begin
    cyc            <= cyc + 1;
    SRAM_read_data <= mem[SRAM_address];
  end

  // Log every new read address
  initial forever begin
    @(negedge Clock);
    if (SRAM_address !== last_addr) begin
      addr_log.push_back(SRAM_address);
      last_addr = SRAM_address;
    end
  end

  // UART decoder: samples mid-bit, records byte and start-bit cycle
  initial forever begin
    @(negedge Clock);
    if (UART_TX_O === 1'b0) begin
      mon_t0 = cyc;
      repeat (C/2) @(negedge Clock);
      if (UART_TX_O !== 1'b0) frame_errs++;
      for (int k = 0; k < 8; k++) begin
        repeat (C) @(negedge Clock);
        mon_b[k] = UART_TX_O;
      end
      repeat (C) @(negedge Clock);
      if (UART_TX_O !== 1'b1) frame_errs++;
      st_q.push_back(mon_t0);
      rx_q.push_back(mon_b);
      repeat (C - C/2 - 1) @(negedge Clock);
    end
  end

  // Expected byte stream for a word list, with trailer when enabled
  function automatic void build_exp(input logic [15:0] w[$]);
    logic [15:0] s;
    s = '0;
    exp_q.delete();
    foreach (w[i]) begin
      exp_q.push_back(w[i][15:8]);
      exp_q.push_back(w[i][7:0]);
      s = s + w[i];
    end
    if (TRAILER == 1) begin
      exp_q.push_back(s[15:8]);
      exp_q.push_back(s[7:0]);
    end
  endfunction

  task automatic clear_logs();
    rx_q.delete();
    st_q.delete();
    addr_log.delete();
  endtask

  task automatic pulse_start(input logic [17:0] a, input logic [17:0] n, output int sc);
    @(negedge Clock);
    Start_address = a;
    Word_count    = n;
    Start         = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    sc    = cyc;
  endtask

  task automatic wait_done(input int limit, output int at, output bit seen);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge Clock);
      if (Done === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clock);
    checks++; if (UART_TX_O !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", UART_TX_O); end
    checks++; if (SRAM_address !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", SRAM_address); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++; if (SRAM_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b expected 1", SRAM_we_n); end
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    $display("reset: tx=%b addr=%h busy=%b done=%b", UART_TX_O, SRAM_address, Busy, Done);
  endtask

  task automatic test_empty();
    int sc;
    bit busy_seen = 1'b0;
    bit low_seen = 1'b0;
    clear_logs();
    pulse_start(18'h00010, 18'd0, sc);
`ifdef UART_TX_CHECKSUM_EN
    begin
      int at;
      bit seen;
      logic [15:0] w[$];
      wait_done(3 * FRAME, at, seen);
      checks++; if (!seen || at != sc + 1 + 2*FRAME) begin errors++; $display("FAIL empty_done_cycle: got %0d expected %0d", at, sc + 1 + 2*FRAME); end
      build_exp(w);
      checks++; if (rx_q.size() != 2 || rx_q[0] != 8'h00 || rx_q[1] != 8'h00) begin errors++; $display("FAIL empty_trailer: got %0d bytes expected 2 zero bytes", rx_q.size()); end
    end
`else
    checks++; if (Done !== 1'b1) begin errors++; $display("FAIL empty_done: got %b expected 1", Done); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b expected 0", Busy); end
    @(negedge Clock);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL empty_done_width: got %b expected 0", Done); end
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (Busy !== 1'b0) busy_seen = 1'b1;
      if (UART_TX_O !== 1'b1) low_seen = 1'b1;
    end
    checks++; if (busy_seen) begin errors++; $display("FAIL empty_busy_window: got 1 expected 0"); end
    checks++; if (low_seen) begin errors++; $display("FAIL empty_line_window: got low expected idle high"); end
`endif
    $display("empty: start_cyc=%0d frames=%0d", sc, rx_q.size());
  endtask

  task automatic test_single();
    int sc, at;
    bit seen;
    logic [15:0] w[$];
    clear_logs();
    mem[5] = 16'hA55A;
    w = '{16'hA55A};
    build_exp(w);
    pulse_start(18'd5, 18'd1, sc);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", Busy); end
    wait_done(30 * FRAME, at, seen);
    checks++; if (!seen || at != sc + 4 + exp_q.size()*FRAME) begin errors++; $display("FAIL single_done_cycle: got %0d expected %0d", at, sc + 4 + exp_q.size()*FRAME); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", Busy); end
    @(negedge Clock);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b expected 0", Done); end
    checks++; if (st_q.size() < 1 || st_q[0] != sc + 4) begin errors++; $display("FAIL single_first_start: got %0d expected %0d", (st_q.size() > 0) ? st_q[0] : -1, sc + 4); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL single_byte_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] != exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (addr_log.size() != 1 || addr_log[0] !== 18'd5) begin errors++; $display("FAIL single_addr: got %0d entries expected one read at 5", addr_log.size()); end
    $display("single: done_cyc=%0d bytes=%0d", at, rx_q.size());
  endtask

  task automatic test_back_to_back();
    int sc, at;
    bit seen;
    logic [15:0] w[$];
    clear_logs();
    mem[18'h100] = 16'h0102;
    mem[18'h101] = 16'h0304;
    mem[18'h102] = 16'h0506;
    w = '{16'h0102, 16'h0304, 16'h0506};
    build_exp(w);
    pulse_start(18'h100, 18'd3, sc);
    wait_done(30 * FRAME, at, seen);
    checks++; if (!seen || at != sc + 4 + exp_q.size()*FRAME) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected %0d", at, sc + 4 + exp_q.size()*FRAME); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_byte_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] != exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    for (int i = 1; i < st_q.size(); i++) begin
      checks++; if (st_q[i] - st_q[i-1] != FRAME) begin errors++; $display("FAIL b2b_gap%0d: got %0d cycles expected %0d", i, st_q[i] - st_q[i-1], FRAME); end
    end
    checks++; if (addr_log.size() != 3) begin errors++; $display("FAIL b2b_addr_count: got %0d expected 3", addr_log.size()); end
    for (int i = 0; i < 3 && i < addr_log.size(); i++) begin
      checks++; if (addr_log[i] !== 18'h100 + 18'(i)) begin errors++; $display("FAIL b2b_addr%0d: got %h expected %h", i, addr_log[i], 18'h100 + 18'(i)); end
    end
    $display("back_to_back: done_cyc=%0d bytes=%0d reads=%0d", at, rx_q.size(), addr_log.size());
  endtask

  task automatic test_wrap_reset();
    int sc, at;
    bit seen;
    bit ok = 1'b0;
    logic [15:0] w[$];
    clear_logs();
    mem[18'h3FFFF] = 16'hBEEF;
    mem[18'h00000] = 16'h1234;
    pulse_start(18'h3FFFF, 18'd2, sc);
    for (int i = 0; i < 4 * FRAME && !ok; i++) begin
      @(negedge Clock);
      if (st_q.size() >= 2 && UART_TX_O === 1'b0 && cyc >= st_q[1] + FRAME) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL wrap_third_frame: got no third start bit expected one"); end
    // Byte 3 started at the cycle ok was found; move into its stop bit
    repeat (9*C + C/4 - 1) @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    checks++; if (UART_TX_O !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b expected 1", UART_TX_O); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", Busy); end
    repeat (2*C) @(negedge Clock);
    checks++; if (addr_log.size() != 2 || addr_log[0] !== 18'h3FFFF || addr_log[1] !== 18'h0) begin errors++; $display("FAIL wrap_addr: got %0d entries expected 3FFFF then 0", addr_log.size()); end
    checks++; if (rx_q.size() != 3 || rx_q[0] != 8'hBE || rx_q[1] != 8'hEF || rx_q[2] != 8'h12) begin errors++; $display("FAIL wrap_bytes: got %0d bytes expected BE EF 12", rx_q.size()); end
    $display("wrap_reset: reads=%0d bytes=%0d", addr_log.size(), rx_q.size());
    Resetn = 1'b1;
    repeat (3) @(negedge Clock);
    clear_logs();
    mem[18'h2A] = 16'h3C81;
    w = '{16'h3C81};
    build_exp(w);
    pulse_start(18'h2A, 18'd1, sc);
    wait_done(30 * FRAME, at, seen);
    checks++; if (!seen || at != sc + 4 + exp_q.size()*FRAME) begin errors++; $display("FAIL restart_done_cycle: got %0d expected %0d", at, sc + 4 + exp_q.size()*FRAME); end
    checks++; if (st_q.size() < 1 || st_q[0] != sc + 4) begin errors++; $display("FAIL restart_first_start: got %0d expected %0d", (st_q.size() > 0) ? st_q[0] : -1, sc + 4); end
    checks++; if (rx_q.size() != exp_q.size() || rx_q[0] != 8'h3C || rx_q[1] != 8'h81) begin errors++; $display("FAIL restart_bytes: got %0d bytes expected 3C 81", rx_q.size()); end
    checks++; if (addr_log.size() != 1 || addr_log[0] !== 18'h2A) begin errors++; $display("FAIL restart_addr: got %0d entries expected one read at 2A", addr_log.size()); end
    $display("restart: done_cyc=%0d bytes=%0d", at, rx_q.size());
  endtask

`ifdef UART_TX_CHECKSUM_EN
  task automatic test_checksum();
    int sc, at;
    bit seen;
    byte unsigned want [6];
    clear_logs();
    mem[18'h200] = 16'hFFFF;
    mem[18'h201] = 16'h0002;
    want = '{8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01};
    pulse_start(18'h200, 18'd2, sc);
    wait_done(30 * FRAME, at, seen);
    checks++; if (!seen || at != sc + 4 + 6*FRAME) begin errors++; $display("FAIL cksum_done_cycle: got %0d expected %0d", at, sc + 4 + 6*FRAME); end
    checks++; if (rx_q.size() != 6) begin errors++; $display("FAIL cksum_byte_count: got %0d expected 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] != want[i]) begin errors++; $display("FAIL cksum_byte%0d: got %h expected %h", i, rx_q[i], want[i]); end
    end
    $display("checksum: done_cyc=%0d bytes=%0d", at, rx_q.size());
  endtask
`endif

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_wrap_reset();
`ifdef UART_TX_CHECKSUM_EN
    test_checksum();
`endif
    checks++; if (frame_errs != 0) begin errors++; $display("FAIL framing: got %0d bad start/stop bits expected 0", frame_errs); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
